// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one ALU operation per handshake, drives the ALU
// decode/operand interface for the operation's latency, captures the
// result and presents it to writeback over a second handshake.
module alu_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int RD_W    = 5,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_funct,
    input  logic             in_imm_sel,
    input  logic [WIDTH-1:0] in_rs_val,
    input  logic [WIDTH-1:0] in_rt_val,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [RD_W-1:0]  in_rd,
    output logic [3:0]       alu_decode,
    output logic [WIDTH-1:0] rda,
    output logic [WIDTH-1:0] rdx,
    input  logic [WIDTH-1:0] alu_result,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_data,
    output logic [RD_W-1:0]  wb_rd,
    output logic             wb_illegal,
    output logic             wb_divz
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [RD_W-1:0]  rd_reg;

    logic [WIDTH-1:0] opb;
    logic [3:0]       dec_code;
    logic [CNT_W-1:0] cnt_init;
    logic             is_illegal;
    logic             is_divz;
    logic             accept;

    // Decode the incoming function code, operand B and per-op latency.
    always_comb begin
        opb        = in_imm_sel ? in_imm : in_rt_val;
        is_illegal = (in_funct > 4'd9);
        is_divz    = (in_funct == 4'd3) && (opb == '0);
        cnt_init   = '0;
        dec_code   = 4'b0000;
        case (in_funct)
            4'd0: dec_code = in_imm_sel ? 4'b0011 : 4'b0001;
            4'd1: dec_code = in_imm_sel ? 4'b0100 : 4'b0010;
            4'd2: begin
                dec_code = 4'b0101;
                cnt_init = CNT_W'(MUL_LAT - 1);
            end
            4'd3: begin
                dec_code = 4'b0110;
                cnt_init = CNT_W'(DIV_LAT - 1);
            end
            4'd4: dec_code = 4'b0111;
            4'd5: dec_code = 4'b1000;
            4'd6: dec_code = 4'b1001;
            4'd7: dec_code = 4'b1010;
            4'd8: dec_code = 4'b1011;
            4'd9: dec_code = 4'b1100;
            default: dec_code = 4'b0000;
        endcase
    end

    // Handshake and ALU-interface outputs; the ALU only sees operands in EXEC.
    always_comb begin
        in_ready   = (state == S_IDLE) && !rst;
        accept     = in_valid && in_ready;
        wb_valid   = (state == S_WB);
        alu_decode = (state == S_EXEC) ? op_reg : 4'b0000;
        rda        = (state == S_EXEC) ? a_reg  : '0;
        rdx        = (state == S_EXEC) ? b_reg  : '0;
    end

    // Sequencer: IDLE accepts, EXEC counts down the latency, WB waits for ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            rd_reg     <= '0;
            wb_data    <= '0;
            wb_rd      <= '0;
            wb_illegal <= 1'b0;
            wb_divz    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_reg <= dec_code;
                        a_reg  <= in_rs_val;
                        b_reg  <= opb;
                        rd_reg <= in_rd;
                        if (is_illegal) begin
                            wb_data    <= '0;
                            wb_rd      <= in_rd;
                            wb_illegal <= 1'b1;
                            state      <= S_WB;
                        end else if (is_divz) begin
                            wb_data <= '1;
                            wb_rd   <= in_rd;
                            wb_divz <= 1'b1;
                            state   <= S_WB;
                        end else begin
                            cnt   <= cnt_init;
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        wb_data <= alu_result;
                        wb_rd   <= rd_reg;
                        state   <= S_WB;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        wb_illegal <= 1'b0;
                        wb_divz    <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed plan steps plus random
// operations, checked against a functional model of each operation.
module tb_alu_issue_ctrl;

    localparam int WIDTH = 32;
    localparam int RD_W  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_funct;
    logic             in_imm_sel;
    logic [WIDTH-1:0] in_rs_val;
    logic [WIDTH-1:0] in_rt_val;
    logic [WIDTH-1:0] in_imm;
    logic [RD_W-1:0]  in_rd;
    logic [3:0]       alu_decode;
    logic [WIDTH-1:0] rda;
    logic [WIDTH-1:0] rdx;
    logic [WIDTH-1:0] alu_result;
    logic             wb_valid;
    logic             wb_ready;
    logic [WIDTH-1:0] wb_data;
    logic [RD_W-1:0]  wb_rd;
    logic             wb_illegal;
    logic             wb_divz;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(WIDTH), .RD_W(RD_W), .MUL_LAT(2), .DIV_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct(in_funct), .in_imm_sel(in_imm_sel),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm), .in_rd(in_rd),
        .alu_decode(alu_decode), .rda(rda), .rdx(rdx), .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_illegal(wb_illegal), .wb_divz(wb_divz)
    );

    // Execute-stage ALU attached to the decode/operand interface.
    always_comb begin
        alu_result = '0;
        case (alu_decode)
            4'b0001, 4'b0011: alu_result = rda + rdx;
            4'b0010, 4'b0100: alu_result = rda - rdx;
            4'b0101: alu_result = rda * rdx;
            4'b0110: alu_result = (rdx != 0) ? rda / rdx : '1;
            4'b0111: alu_result = rda | rdx;
            4'b1000: alu_result = rda & rdx;
            4'b1001: alu_result = rda ^ rdx;
            4'b1010: alu_result = rda << rdx[4:0];
            4'b1011: alu_result = rda >> rdx[4:0];
            4'b1100: alu_result = {31'd0, rda < rdx};
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: what one operation should produce, from the function code.
    function automatic logic [31:0] ref_result(input int f, input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        case (f)
            0: return a + b;
            1: return a - b;
            2: begin p = longint'(a) * longint'(b); return p[31:0]; end
            3: return a / b;
            4: return a | b;
            5: return a & b;
            6: return a ^ b;
            7: return a << (b % 32);
            8: return a >> (b % 32);
            9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] ref_code(input int f, input bit imm);
        logic [3:0] tbl [0:9] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
        if (f > 9) return 4'd0;
        if (imm && f == 0) return 4'd3;
        if (imm && f == 1) return 4'd4;
        return tbl[f];
    endfunction

    // Runs one operation starting at a falling edge with the block idle.
    // While busy, in_valid and the input fields are randomized to show they are ignored.
    task automatic run_op(input int f, input bit imm_sel, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] imm,
                          input logic [4:0] rd, input int bp);
        logic [31:0] b, exp_data;
        bit          ill, dz;
        int          lat, n;
        b   = imm_sel ? imm : rt;
        ill = (f > 9);
        dz  = (f == 3) && (b == 0);
        lat = (ill || dz) ? 0 : (f == 2) ? 2 : (f == 3) ? 4 : 1;
        exp_data = ill ? 32'd0 : dz ? 32'hFFFF_FFFF : ref_result(f, rs, b);

        in_valid   = 1'b1;
        in_funct   = 4'(f);
        in_imm_sel = imm_sel;
        in_rs_val  = rs;
        in_rt_val  = rt;
        in_imm     = imm;
        in_rd      = rd;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid   = 1'($urandom);
        in_funct   = 4'($urandom);
        in_imm_sel = 1'($urandom);
        in_rs_val  = $urandom;
        in_rt_val  = $urandom;
        in_imm     = $urandom;
        in_rd      = 5'($urandom);
        n = 0;
        while (!wb_valid && n < 20) begin
            chk("exec_decode", 32'(alu_decode), 32'(ref_code(f, imm_sel)));
            chk("exec_rda", rda, rs);
            chk("exec_rdx", rdx, b);
            chk("exec_in_ready", 32'(in_ready), 32'd0);
            n++;
            @(negedge clk);
        end
        chk("exec_cycles", n, lat);
        for (int i = 0; i <= bp; i++) begin
            wb_ready = (i == bp);
            chk("wb_valid", 32'(wb_valid), 32'd1);
            chk("wb_data", wb_data, exp_data);
            chk("wb_rd", 32'(wb_rd), 32'(rd));
            chk("wb_illegal", 32'(wb_illegal), 32'(ill));
            chk("wb_divz", 32'(wb_divz), 32'(dz));
            chk("wb_decode_idle", 32'(alu_decode), 32'd0);
            chk("wb_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        wb_ready = 1'b0;
        in_valid = 1'b0;
        chk("post_wb_valid", 32'(wb_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_flags", {30'd0, wb_illegal, wb_divz}, 32'd0);
        chk("post_wb_data_kept", wb_data, exp_data);
        chk("post_wb_rd_kept", 32'(wb_rd), 32'(rd));
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {27'd0, in_ready, wb_valid, wb_illegal, wb_divz, |alu_decode}, 32'd0);
        chk(tag, rda | rdx | wb_data | 32'(wb_rd), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b0;
        in_funct = '0; in_imm_sel = 1'b0; in_rs_val = '0; in_rt_val = '0;
        in_imm = '0; in_rd = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        run_op(0, 1'b1, 5, 99, 7, 3, 0);                  // ADD imm -> 12
        run_op(2, 1'b0, 6, 7, 0, 9, 5);                   // MUL backpressure -> 42
        run_op(3, 1'b0, 9, 0, 0, 1, 1);                   // DIV by zero
        run_op(3, 1'b0, 9, 3, 0, 2, 0);                   // DIV -> 3
        run_op(12, 1'b0, 1, 2, 3, 4, 0);                  // illegal
        run_op(1, 1'b0, 10, 4, 0, 5, 0);                  // SUB -> 6

        // Reset during the second EXEC cycle of a DIV drops the operation.
        in_valid = 1'b1; in_funct = 4'd3; in_imm_sel = 1'b0;
        in_rs_val = 100; in_rt_val = 7; in_rd = 6;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_div_decode", 32'(alu_decode), 32'd6);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset_outputs");
        rst = 1'b0;
        @(negedge clk);
        chk("after_reset_ready", 32'(in_ready), 32'd1);
        chk("after_reset_no_wb", 32'(wb_valid), 32'd0);
        run_op(0, 1'b0, 1, 1, 0, 7, 0);                   // ADD 1+1 -> 2

        // Back-to-back with in_valid effectively held high between ops.
        run_op(7, 1'b0, 1, 33, 0, 8, 0);                  // SLL -> 2
        run_op(8, 1'b0, 32'h80, 4, 0, 9, 0);              // SRL -> 8
        run_op(9, 1'b0, 2, 3, 0, 10, 0);                  // SLT -> 1

        for (int k = 0; k < 40; k++) begin
            logic [31:0] rt;
            rt = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_op(int'($urandom_range(0, 15)), 1'($urandom), $urandom, rt,
                   ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                   5'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
